// File: rtl/eth_frame_detector_pkg.sv
// Shared types and sizes for the frame detector pattern memory ports.
package eth_frame_detector_pkg;

    localparam int MEM_ADDR_W = 11;
    localparam int MEM_DEPTH  = 2048;
    localparam int STALL_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ACK,
        ST_COOLDOWN
    } mem_port_state_t;

endpackage

// File: rtl/eth_frame_detector_mem_ram.sv
// Inferred single-port pattern RAM: registered read, write-enable, no reset.
// A write cycle leaves the read register untouched.
module eth_frame_detector_mem_ram
    import eth_frame_detector_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [MEM_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/eth_frame_detector_mem_port.sv
// Pattern RAM responder: host mem_req/ack port arbitrated against a fixed-latency
// detector read port. Optional stall statistic: ETH_FRAME_DETECTOR_MEM_STALL_CNT_EN.
module eth_frame_detector_mem_port
    import eth_frame_detector_pkg::*;
#(
    parameter int C_AXI_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_req,
    input  logic                   mem_we,
    output logic                   mem_ack,
    input  logic [MEM_ADDR_W-1:0]  mem_addr,
    input  logic [C_AXI_WIDTH-1:0] mem_wdata,
    output logic [C_AXI_WIDTH-1:0] mem_rdata,
    input  logic                   det_en,
    input  logic [MEM_ADDR_W-1:0]  det_addr,
    output logic [C_AXI_WIDTH-1:0] det_rdata,
    input  logic                   stall_clr,
    output logic [STALL_W-1:0]     stall_count
);

    mem_port_state_t          state_q, state_d;
    logic [MEM_ADDR_W-1:0]    addr_q, addr_d;
    logic                     we_q, we_d;
    logic [C_AXI_WIDTH-1:0]   wdata_q, wdata_d;
    logic [C_AXI_WIDTH-1:0]   rdata_hold_q, rdata_hold_d;
    logic                     det_vld_q, det_vld_d;
    logic [C_AXI_WIDTH-1:0]   det_hold_q, det_hold_d;

    logic                     ram_en, ram_we;
    logic [MEM_ADDR_W-1:0]    ram_addr;
    logic [C_AXI_WIDTH-1:0]   ram_rdata;

    eth_frame_detector_mem_ram #(.DATA_W(C_AXI_WIDTH)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // Detector always wins the port; rst gates the RAM so an aborted write never lands.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = addr_q;
        if (!rst) begin
            if (det_en) begin
                ram_en   = 1'b1;
                ram_addr = det_addr;
            end else if (state_q == ST_ACCESS) begin
                ram_en   = 1'b1;
                ram_we   = we_q;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        rdata_hold_d = rdata_hold_q;
        mem_ack      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    addr_d  = mem_addr;
                    we_d    = mem_we;
                    wdata_d = mem_wdata;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!det_en) state_d = ST_ACK;
            end
            ST_ACK: begin
                mem_ack = 1'b1;
                if (!we_q) rdata_hold_d = ram_rdata;
                state_d = ST_COOLDOWN;
            end
            ST_COOLDOWN: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // The RAM read register is shared, so each consumer keeps its own hold copy.
    assign mem_rdata  = (state_q == ST_ACK && !we_q) ? ram_rdata : rdata_hold_q;
    assign det_vld_d  = det_en;
    assign det_hold_d = det_vld_q ? ram_rdata : det_hold_q;
    assign det_rdata  = det_hold_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            rdata_hold_q <= '0;
            det_vld_q    <= 1'b0;
            det_hold_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            rdata_hold_q <= rdata_hold_d;
            det_vld_q    <= det_vld_d;
            det_hold_q   <= det_hold_d;
        end
    end

`ifdef ETH_FRAME_DETECTOR_MEM_STALL_CNT_EN
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr) begin
            stall_cnt_d = '0;
        end else if (state_q == ST_ACCESS && det_en && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_count = stall_cnt_q;
`else
    logic stall_clr_unused;
    assign stall_clr_unused = stall_clr;
    assign stall_count      = '0;
`endif

endmodule

// File: tb/tb_eth_frame_detector_mem_port.sv
// Scoreboard bench for eth_frame_detector_mem_port: stimulus pushes expected
// acks / detector data; negedge monitor pops and compares.
module tb_eth_frame_detector_mem_port;

    localparam int W = 32;
`ifdef ETH_FRAME_DETECTOR_MEM_STALL_CNT_EN
    localparam int STALL_N    = 70000;
    localparam bit CNT_ON     = 1'b1;
`else
    localparam int STALL_N    = 20;
    localparam bit CNT_ON     = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, mem_req, mem_we, mem_ack, det_en, stall_clr;
    logic [10:0]   mem_addr, det_addr;
    logic [W-1:0]  mem_wdata, mem_rdata, det_rdata;
    logic [15:0]   stall_count;

    eth_frame_detector_mem_port #(.C_AXI_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .det_en(det_en), .det_addr(det_addr), .det_rdata(det_rdata),
        .stall_clr(stall_clr), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; bit is_rd; logic [W-1:0] data; } ack_exp_t;
    typedef struct { int cyc; logic [W-1:0] data; } det_exp_t;

    ack_exp_t     ack_q[$];
    det_exp_t     det_q[$];
    logic [W-1:0] model [0:2047];
    int           cyc = 0;
    int           checks = 0, errors = 0, ack_seen = 0;
    ack_exp_t     ae;
    det_exp_t     de;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && mem_ack) begin
            ack_seen++;
            if (ack_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
            end else begin
                ae = ack_q.pop_front();
                check("ack_cycle", 64'(cyc), 64'(ae.cyc));
                if (ae.is_rd) check("mem_rdata", 64'(mem_rdata), 64'(ae.data));
            end
        end
        if (det_q.size() > 0 && det_q[0].cyc == cyc) begin
            de = det_q.pop_front();
            check("det_rdata", 64'(det_rdata), 64'(de.data));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Call in an IDLE cycle just after the edge; returns in the next IDLE cycle.
    task automatic host_op(input bit we, input logic [10:0] addr, input logic [W-1:0] data,
                           input int stall, input bit linger, input int budget);
        ack_exp_t e;
        int n0;
        mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = data;
        e.cyc = cyc + 2 + stall; e.is_rd = !we; e.data = we ? '0 : model[addr];
        ack_q.push_back(e);
        if (we) model[addr] = data;
        n0 = ack_seen;
        for (int i = 0; i < budget && ack_seen == n0; i++) begin
            @(negedge clk); #1;
        end
        if (ack_seen == n0) begin
            checks++; errors++;
            $display("FAIL ack_timeout: got no ack expected one by cycle %0d", e.cyc);
            ack_q.delete();
        end
        if (!linger) mem_req = 1'b0;
        idle(1);
        idle(1);
        mem_req = 1'b0;
    endtask

    task automatic det_read(input logic [10:0] addr);
        det_exp_t d;
        det_en = 1'b1; det_addr = addr;
        d.cyc = cyc + 1; d.data = model[addr];
        det_q.push_back(d);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        for (int i = 0; i < 2048; i++) model[i] = '0;
        rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
        det_en = 1'b0; det_addr = '0; stall_clr = 1'b0;
        idle(3);
        rst = 1'b0;
        check("rst_mem_ack", 64'(mem_ack), 64'(0));
        check("rst_mem_rdata", 64'(mem_rdata), 64'(0));
        check("rst_det_rdata", 64'(det_rdata), 64'(0));
        check("rst_stall_count", 64'(stall_count), 64'(0));

        // Uncontended write then read, read data held afterwards
        host_op(1'b1, 11'h005, 32'hDEADBEEF, 0, 1'b0, 20);
        host_op(1'b0, 11'h005, '0, 0, 1'b0, 20);
        idle(3);
        check("rdata_hold", 64'(mem_rdata), 64'h0DEADBEEF);
        host_op(1'b1, 11'h010, 32'h12345678, 0, 1'b0, 20);
        check("write_keeps_rdata", 64'(mem_rdata), 64'h0DEADBEEF);

        // Contended read: detector owns the port for 5 ACCESS cycles
        fork
            host_op(1'b0, 11'h010, '0, 5, 1'b0, 40);
            begin
                idle(1);
                for (int i = 0; i < 5; i++) begin
                    det_read((i % 2) != 0 ? 11'h005 : 11'h010);
                    idle(1);
                end
                det_en = 1'b0;
            end
        join
        idle(2);
        check("det_hold", 64'(det_rdata), 64'h012345678);

        // Detector read in the cycle right after the host write executes
        fork
            host_op(1'b1, 11'h030, 32'hCAFEF00D, 0, 1'b0, 20);
            begin
                idle(2);
                det_read(11'h030);
                idle(1);
                det_en = 1'b0;
            end
        join

        // Lingering request through COOLDOWN yields exactly one ack
        n0 = ack_seen;
        host_op(1'b0, 11'h005, '0, 0, 1'b1, 20);
        idle(4);
        check("linger_ack_count", 64'(ack_seen - n0), 64'(1));

        // Reset during ACCESS aborts the write
        host_op(1'b1, 11'h020, 32'h11112222, 0, 1'b0, 20);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 11'h020; mem_wdata = 32'hAAAA5555;
        idle(1);
        rst = 1'b1; mem_req = 1'b0;
        idle(1);
        rst = 1'b0;
        check("rst_abort_ack", 64'(mem_ack), 64'(0));
        check("rst_abort_rdata", 64'(mem_rdata), 64'(0));
        idle(1);
        check("rst_abort_ack_idle", 64'(mem_ack), 64'(0));
        host_op(1'b0, 11'h020, '0, 0, 1'b0, 20);

        // Address extremes
        host_op(1'b1, 11'h7FF, 32'h00000001, 0, 1'b0, 20);
        host_op(1'b1, 11'h000, 32'h00000002, 0, 1'b0, 20);
        host_op(1'b0, 11'h7FF, '0, 0, 1'b0, 20);
        host_op(1'b0, 11'h000, '0, 0, 1'b0, 20);

        // Long contention: stall counter saturates (or stays 0 when compiled out)
        fork
            host_op(1'b0, 11'h7FF, '0, STALL_N, 1'b0, STALL_N + 100);
            begin
                idle(1);
                det_en = 1'b1; det_addr = 11'h000;
                idle(10);
                check("stall_count_10", 64'(stall_count), CNT_ON ? 64'd10 : 64'd0);
                idle(STALL_N - 10);
                det_en = 1'b0;
                check("stall_count_sat", 64'(stall_count), CNT_ON ? 64'hFFFF : 64'd0);
            end
        join
        stall_clr = 1'b1;
        idle(1);
        stall_clr = 1'b0;
        check("stall_count_clr", 64'(stall_count), 64'd0);

        idle(3);
        check("ack_queue_empty", 64'(ack_q.size()), 64'd0);
        check("det_queue_empty", 64'(det_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
